// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and latched transfer configuration for the SPI master.
package spi_pkg;

  localparam int unsigned SPI_BITS  = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned EDGE_W    = 5;
  localparam int unsigned NUM_EDGES = 2 * SPI_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_cfg_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, edge counter, sclk register and one-cycle edge strobes.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  output logic              sclk,
  output logic              leading_edge,
  output logic              trailing_edge,
  output logic              hold_done,
  output logic [EDGE_W-1:0] edge_cnt
);

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(NUM_EDGES);

  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              lead_q, lead_d;
  logic              trail_q, trail_d;
  logic              done_q, done_d;
  logic              strobe_d;

  // Strobes are computed from next-state counters so they are high in the
  // same cycle the sclk register is about to toggle.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      edge_d = '0;
      sclk_d = cpol;
    end else if (!run_q) begin
      cnt_d  = '0;
      edge_d = '0;
      sclk_d = cpol;
    end else if (cnt_q == DIV_LAST) begin
      cnt_d = '0;
      if (edge_q == EDGE_LAST) begin
        run_d  = 1'b0;
        edge_d = '0;
        sclk_d = cpol;
      end else begin
        edge_d = edge_q + EDGE_W'(1);
        sclk_d = ~sclk_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    strobe_d = run_d && (cnt_d == DIV_LAST);
    lead_d   = strobe_d && (edge_d != EDGE_LAST) && !edge_d[0];
    trail_d  = strobe_d && edge_d[0];
    done_d   = strobe_d && (edge_d == EDGE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      done_q  <= done_d;
    end
  end

  assign sclk          = sclk_q;
  assign leading_edge  = lead_q;
  assign trailing_edge = trail_q;
  assign hold_done     = done_q;
  assign edge_cnt      = edge_q;

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, modes 0-3, MSB first; CPOL/CPHA latched per transfer.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CPOL,
  input  logic                CPHA,
  input  logic                tx_dp,
  input  logic [SPI_BITS-1:0] Tx_byte,
  input  logic                MISO,
  output logic                sclk,
  output logic                MOSI,
  output logic                CS,
  output logic [SPI_BITS-1:0] Rx_byte,
  output logic                busy,
  output logic                master_done
);

  logic [1:0]          state_q, state_d;
  spi_cfg_t            cfg_q, cfg_d;
  logic [SPI_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                mosi_q, mosi_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_c;
  logic                gen_cpol_c;
  logic                sample_c;
  logic                shift_c;
  logic                leading_edge;
  logic                trailing_edge;
  logic                hold_done;
  logic [EDGE_W-1:0]   edge_cnt;

  // A start in the master_done cycle is dropped so CS always sees a high gap.
  assign accept_c   = (state_q == ST_IDLE) && tx_dp && !done_q;
  assign gen_cpol_c = (state_q == ST_IDLE) ? CPOL : cfg_q.cpol;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk          (clk),
    .rst          (rst),
    .start        (accept_c),
    .cpol         (gen_cpol_c),
    .sclk         (sclk),
    .leading_edge (leading_edge),
    .trailing_edge(trailing_edge),
    .hold_done    (hold_done),
    .edge_cnt     (edge_cnt)
  );

  // edge_cnt holds k-1 while the strobe for edge k is high.
  assign sample_c = cfg_q.cpha ? trailing_edge : leading_edge;
  assign shift_c  = cfg_q.cpha ? leading_edge
                               : (trailing_edge && (edge_cnt < EDGE_W'(NUM_EDGES - 2)));

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (sample_c) begin
      rx_sh_d = {rx_sh_q[SPI_BITS-2:0], MISO};
    end
    if (shift_c) begin
      mosi_d  = tx_sh_q[SPI_BITS-1];
      tx_sh_d = {tx_sh_q[SPI_BITS-2:0], 1'b0};
    end

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (accept_c) begin
          state_d    = ST_SETUP;
          cfg_d.cpol = CPOL;
          cfg_d.cpha = CPHA;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          rx_sh_d    = '0;
          if (CPHA) begin
            tx_sh_d = Tx_byte;
          end else begin
            mosi_d  = Tx_byte[SPI_BITS-1];
            tx_sh_d = {Tx_byte[SPI_BITS-2:0], 1'b0};
          end
        end
      end
      ST_SETUP: begin
        if (leading_edge) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (trailing_edge && (edge_cnt == EDGE_W'(NUM_EDGES - 1))) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_done) begin
          state_d   = ST_IDLE;
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_byte_d = rx_sh_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= '0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign MOSI        = mosi_q;
  assign CS          = cs_q;
  assign Rx_byte     = rx_byte_q;
  assign busy        = busy_q;
  assign master_done = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=2 instance with a slave model, CLK_DIV=4 instance for mode 3.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha;
  logic       tx_dp0, tx_dp1;
  logic [7:0] tx_byte;
  logic       miso0, miso1;

  logic       sclk0, mosi0, cs0, busy0, done0;
  logic [7:0] rx0;
  logic       sclk1, mosi1, cs1, busy1, done1;
  logic [7:0] rx1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign miso1 = 1'b1;

  spi_master #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .CPOL(cpol), .CPHA(cpha), .tx_dp(tx_dp0), .Tx_byte(tx_byte),
    .MISO(miso0), .sclk(sclk0), .MOSI(mosi0), .CS(cs0), .Rx_byte(rx0), .busy(busy0),
    .master_done(done0)
  );

  spi_master #(.CLK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .CPOL(cpol), .CPHA(cpha), .tx_dp(tx_dp1), .Tx_byte(tx_byte),
    .MISO(miso1), .sclk(sclk1), .MOSI(mosi1), .CS(cs1), .Rx_byte(rx1), .busy(busy1),
    .master_done(done1)
  );

  // Slave for dut0: shifts slave_byte out on MISO and captures MOSI on sample edges.
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] s_sh       = 8'h00;
  logic [7:0] mosi_cap0  = 8'h00;
  logic       s_prev     = 1'b0;
  int         s_edges    = 0;

  initial miso0 = 1'b0;

  always @(negedge clk) begin
    if (cs0) begin
      s_edges = 0;
      s_sh    = slave_byte;
      miso0   = slave_byte[7];
      s_prev  = sclk0;
    end else if (sclk0 !== s_prev) begin
      s_prev  = sclk0;
      s_edges = s_edges + 1;
      if ((s_edges % 2 == 1) ^ cpha) begin
        if (s_edges <= 2) mosi_cap0 = {7'b0, mosi0};
        else              mosi_cap0 = {mosi_cap0[6:0], mosi0};
      end else if (cpha) begin
        miso0 = s_sh[7];
        s_sh  = {s_sh[6:0], 1'b0};
      end else begin
        s_sh  = {s_sh[6:0], 1'b0};
        miso0 = s_sh[7];
      end
    end
  end

  // Monitor for dut1 (mode 3): capture MOSI on rising sclk, flag MOSI moves off falling edges.
  logic [7:0] m1_cap   = 8'h00;
  int         m1_rises = 0;
  int         m1_bad   = 0;
  logic       p_sclk1  = 1'b0;
  logic       p_mosi1  = 1'b0;

  always @(negedge clk) begin
    if (!cs1) begin
      if (sclk1 && !p_sclk1) begin
        m1_cap   = {m1_cap[6:0], mosi1};
        m1_rises = m1_rises + 1;
      end
      if ((mosi1 !== p_mosi1) && !(p_sclk1 && !sclk1)) m1_bad = m1_bad + 1;
    end
    p_sclk1 = sclk1;
    p_mosi1 = mosi1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CLK_DIV=2 transfer on dut0 started in the current cycle; ends in the master_done cycle.
  // extra_at > 0 pulses tx_dp with Tx_byte=00 in that relative cycle.
  task automatic xfer0(input logic [7:0] tx, input logic [7:0] sl, input int extra_at,
                       input string tag);
    logic ps;
    ps         = sclk0;
    tx_byte    = tx;
    slave_byte = sl;
    tx_dp0     = 1'b1;
    tick;
    tx_dp0  = 1'b0;
    tx_byte = 8'h00;
    for (int c = 1; c <= 35; c++) begin
      chk($sformatf("%s_cs_c%0d", tag, c), 32'(cs0), (c <= 34) ? 32'd0 : 32'd1);
      chk($sformatf("%s_sclk_toggle_c%0d", tag, c), 32'(sclk0 !== ps),
          (c >= 3 && c <= 33 && (c % 2 == 1)) ? 32'd1 : 32'd0);
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done0), (c == 35) ? 32'd1 : 32'd0);
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy0), (c <= 34) ? 32'd1 : 32'd0);
      if (c == 1 && !cpha) chk($sformatf("%s_first_mosi", tag), 32'(mosi0), 32'(tx[7]));
      ps = sclk0;
      if (c == extra_at) begin
        tx_dp0  = 1'b1;
        tx_byte = 8'h00;
      end
      if (c < 35) begin
        tick;
        tx_dp0 = 1'b0;
      end
    end
    chk($sformatf("%s_mosi_stream", tag), 32'(mosi_cap0), 32'(tx));
    chk($sformatf("%s_rx_byte", tag), 32'(rx0), 32'(sl));
  endtask

  initial begin
    int ndone;
    rst     = 1'b1;
    cpol    = 1'b1;
    cpha    = 1'b0;
    tx_dp0  = 1'b0;
    tx_dp1  = 1'b0;
    tx_byte = 8'h00;
    tick;
    tx_dp0 = 1'b1;
    tick;
    tx_dp0 = 1'b0;

    // Reset state, with CPOL=1 and tx_dp overridden by reset.
    chk("rst_cs", 32'(cs0), 32'd1);
    chk("rst_sclk", 32'(sclk0), 32'd0);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_rx", 32'(rx0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_cs1", 32'(cs1), 32'd1);
    chk("rst_sclk1", 32'(sclk1), 32'd0);

    rst = 1'b0;
    tick;
    chk("post_rst_sclk_cpol1", 32'(sclk0), 32'd1);
    cpol = 1'b0;
    tick;
    chk("idle_sclk_cpol0", 32'(sclk0), 32'd0);
    chk("idle_cs", 32'(cs0), 32'd1);

    // Mode 0, A5 out, 3C in.
    cpol = 1'b0;
    cpha = 1'b0;
    tick;
    xfer0(8'hA5, 8'h3C, 0, "mode0");
    tick;
    chk("mode0_done_one_cycle", 32'(done0), 32'd0);
    chk("mode0_rx_hold", 32'(rx0), 32'h3C);

    // Second start during a transfer is ignored.
    tick;
    xfer0(8'h5A, 8'hC6, 10, "busy_ign");
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done0) ndone++;
    end
    chk("busy_ign_no_extra_done", 32'(ndone), 32'd0);
    chk("busy_ign_cs_idle", 32'(cs0), 32'd1);

    // Back-to-back: start in master_done cycle dropped, next cycle accepted.
    xfer0(8'h96, 8'h69, 35, "b2b1");
    tick;
    tx_dp0 = 1'b0;
    chk("b2b_cs_high_gap", 32'(cs0), 32'd1);
    chk("b2b_busy_gap", 32'(busy0), 32'd0);
    chk("b2b_rx_first", 32'(rx0), 32'h69);
    xfer0(8'h3B, 8'hD4, 0, "b2b2");

    // Reset mid-transfer in mode 2 (CPOL=1, CPHA=0).
    tick;
    cpol = 1'b1;
    cpha = 1'b0;
    tick;
    chk("mode2_idle_sclk", 32'(sclk0), 32'd1);
    tx_byte    = 8'hA5;
    slave_byte = 8'hF0;
    tx_dp0     = 1'b1;
    tick;
    tx_dp0 = 1'b0;
    for (int c = 1; c < 12; c++) tick;
    chk("abort_cs_low_t12", 32'(cs0), 32'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_cs", 32'(cs0), 32'd1);
    chk("abort_sclk", 32'(sclk0), 32'd0);
    chk("abort_mosi", 32'(mosi0), 32'd0);
    chk("abort_rx", 32'(rx0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    tick;
    chk("abort_sclk_follows_cpol", 32'(sclk0), 32'd1);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done0) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_rx_hold", 32'(rx0), 32'd0);
    xfer0(8'hC3, 8'h5A, 0, "post_abort");
    tick;
    chk("post_abort_sclk_idle", 32'(sclk0), 32'd1);

    // Mode 3 on the CLK_DIV=4 instance.
    cpol = 1'b1;
    cpha = 1'b1;
    tick;
    chk("mode3_idle_sclk_high", 32'(sclk1), 32'd1);
    tx_byte = 8'h81;
    tx_dp1  = 1'b1;
    tick;
    tx_dp1  = 1'b0;
    tx_byte = 8'h00;
    for (int c = 1; c <= 69; c++) begin
      chk($sformatf("mode3_cs_c%0d", c), 32'(cs1), (c <= 68) ? 32'd0 : 32'd1);
      chk($sformatf("mode3_done_c%0d", c), 32'(done1), (c == 69) ? 32'd1 : 32'd0);
      if (c < 69) tick;
    end
    chk("mode3_rx", 32'(rx1), 32'hFF);
    chk("mode3_mosi_stream", 32'(m1_cap), 32'h81);
    chk("mode3_rising_edges", 32'(m1_rises), 32'd8);
    chk("mode3_mosi_on_falling_only", 32'(m1_bad), 32'd0);
    chk("mode3_sclk_ends_high", 32'(sclk1), 32'd1);
    chk("mode3_dut0_untouched", 32'(cs0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
